// File: rtl/key12_encoder.sv
// rtl/key12_encoder.sv - 12-key active-low pushbutton encoder with debounce
// Synchronizes and debounces the key vector as a whole, then emits one code pulse per accepted press.
module key12_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] inkey,
  output logic [3:0]  code,
  output logic        code_valid,
  output logic        key_held,
  output logic        multi_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, ERR} state_t;

  logic [11:0]   s1, s2, s3, deb;
  logic [CW-1:0] cnt;
  state_t        state;
  logic [3:0]    idx;
  logic          one_hot;

  // Any bit change restarts the window for the whole vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      cnt <= '0;
      deb <= '0;
    end else begin
      s1 <= ~inkey;
      s2 <= s1;
      s3 <= s2;
      if (s2 != s3) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        deb <= s2;
      end
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (deb[i]) idx = 4'(i);
    end
    one_hot = (deb != '0) && ((deb & (deb - 12'd1)) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code       <= 4'hF;
      code_valid <= 1'b0;
      key_held   <= 1'b0;
      multi_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (one_hot) begin
            code       <= 4'd11 - idx;
            code_valid <= 1'b1;
            key_held   <= 1'b1;
            state      <= HELD;
          end else if (deb != '0) begin
            multi_err <= 1'b1;
            state     <= ERR;
          end
        end
        HELD, ERR: begin
          // Added keys while held are ignored; only a full release rearms.
          if (deb == '0) begin
            key_held  <= 1'b0;
            multi_err <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key12_encoder.sv
// tb/tb_key12_encoder.sv - scoreboard bench for key12_encoder
module tb_key12_encoder;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] inkey;
  logic [3:0]  code;
  logic        code_valid, key_held, multi_err;

  key12_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .inkey(inkey), .code(code),
    .code_valid(code_valid), .key_held(key_held), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [3:0] code; int edge_no; } ev_t;
  ev_t exp_q[$];

  // Reference: deb takes a sampled vector once DC+1 consecutive post-reset samples agree,
  // seen two clocks late through the synchronizer; key events are judged on deb.
  logic [11:0] hist[$];
  logic [11:0] deb_m;
  logic [3:0]  code_m;
  logic        valid_m, held_m, err_m;
  int          ecount = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < 3; k++) hist.push_back(12'h000);
      deb_m = '0; code_m = 4'hF; valid_m = 0; held_m = 0; err_m = 0;
    end else begin
      int sz;
      bit ok;
      ecount++;
      valid_m = 0;
      if (!held_m && !err_m) begin
        if ($countones(deb_m) == 1) begin
          for (int i = 0; i < 12; i++) if (deb_m[i]) code_m = 4'(11 - i);
          valid_m = 1;
          held_m = 1;
          exp_q.push_back('{code_m, ecount});
        end else if (deb_m != 0) begin
          err_m = 1;
        end
      end else if (deb_m == 0) begin
        held_m = 0;
        err_m = 0;
      end
      sz = hist.size();
      if (sz >= DC + 2) begin
        ok = 1;
        for (int k = sz - 2 - DC; k <= sz - 2; k++) if (hist[k] != hist[sz-2]) ok = 0;
        if (ok) deb_m = hist[sz-2];
      end
      hist.push_back(~inkey);
      if (hist.size() > 32) void'(hist.pop_front());
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("code_valid", code_valid, valid_m);
        chk("key_held", key_held, held_m);
        chk("multi_err", multi_err, err_m);
        chk("code", code, code_m);
        if (code_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("pulse_code", code, e.code);
            chk("pulse_edge", ecount, e.edge_no);
          end
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!code_valid && n < 40);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while ((key_held || multi_err) && n < 40);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_code", code, 4'hF);
    chk("rst_valid", code_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_err", multi_err, 0);
    cycles(2); #2;
    rst_n = 1;
  endtask

  initial begin
    int n;
    rst_n = 0;
    inkey = 12'hFFF;
    cycles(3); #2;
    rst_n = 1;
    cycles(10);

    @(negedge clk) inkey = 12'h7FF;
    wait_valid(n);
    chk("press_latency", n, 8);
    chk("press_code", code, 0);
    chk("press_held", key_held, 1);
    cycles(10);
    @(negedge clk) inkey = 12'hFFF;
    wait_idle(n);
    chk("release_latency", n, 8);
    cycles(4);

    for (int i = 0; i < 12; i++) begin
      logic [11:0] v;
      v = ~(12'd1 << i);
      @(negedge clk) inkey = v;
      wait_valid(n);
      chk("sweep_latency", n, 8);
      chk("sweep_code", code, 11 - i);
      cycles(6);
      @(negedge clk) inkey = 12'hFFF;
      cycles(12);
    end

    for (int k = 0; k < 10; k++) begin
      @(negedge clk) inkey = (k % 2 == 0) ? 12'hFDF : 12'hFFF;
      cycles(2);
    end
    @(negedge clk) inkey = 12'hFDF;
    wait_valid(n);
    chk("bounce_latency", n, 8);
    chk("bounce_code", code, 6);
    cycles(4);
    @(negedge clk) inkey = 12'hFFF;
    cycles(12);

    @(negedge clk) inkey = 12'hFFC;
    cycles(12);
    chk("multi_err_set", multi_err, 1);
    chk("multi_code_kept", code, 6);
    @(negedge clk) inkey = 12'hFFF;
    wait_idle(n);
    chk("multi_release_latency", n, 8);
    cycles(4);

    @(negedge clk) inkey = 12'hFF7;
    wait_valid(n);
    chk("hold3_code", code, 8);
    @(negedge clk) inkey = 12'hDF7;
    cycles(12);
    chk("added_held", key_held, 1);
    chk("added_no_err", multi_err, 0);
    @(negedge clk) inkey = 12'hFFF;
    cycles(12);
    @(negedge clk) inkey = 12'hDFF;
    wait_valid(n);
    chk("line9_code", code, 2);
    cycles(3);

    inkey = 12'hFFF;
    do_reset();
    cycles(12);

    @(negedge clk) inkey = 12'hEFF;
    cycles(4);
    do_reset();
    cycles(12);

    for (int it = 0; it < 80; it++) begin
      logic [11:0] v;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: v = 12'hFFF;
        1, 2: v = ~(12'd1 << $urandom_range(0, 11));
        default: v = ~((12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11)));
      endcase
      @(negedge clk) inkey = v;
      cycles($urandom_range(0, 11));
    end
    @(negedge clk) inkey = 12'hFFF;
    cycles(20);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/key12_encoder.md
# key12_encoder

Encoder for the 12-key board inputs, the input-side counterpart of the 4-bit-to-12-LED one-hot decoder. It samples 12 active-low pushbuttons and synchronizes and debounces them as one vector. It emits a 4-bit key code with a one-cycle valid strobe per accepted press, using the index mapping the decoder uses: code 0 corresponds to line 11, code 11 to line 0. Multi-key presses are flagged, not encoded.

## Interface
- `DEBOUNCE_CYCLES`, default 250000, consecutive stable clocks required before the debounced vector updates. Minimum 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `inkey`  input  12  raw pushbuttons, active-low (0 = pressed), asynchronous to `clk`.
- `code`  output  4  last accepted key code, 0..11; 4'b1111 = none since reset.
- `code_valid`  output  1  one-cycle pulse when `code` is updated.
- `key_held`  output  1  level; an accepted key is still down.
- `multi_err`  output  1  level; more than one key is debounced-down.

## Operation
- **Synchronizer**: two flops on `~inkey`, giving stage s2, active-high. s3 is s2 delayed one clock.
- **Debounce counter `cnt`**:
  - s2 != s3: `cnt` <= 0.
  - s2 == s3 and `cnt` < DEBOUNCE_CYCLES-1: `cnt` increments.
  - s2 == s3 and `cnt` == DEBOUNCE_CYCLES-1: `deb` <= s2, `cnt` holds (saturates).
  - Any change of any bit restarts the count for the whole vector.
- **FSM** on `deb`, states IDLE, HELD, ERR:
  - IDLE, `deb` == 0: stay.
  - IDLE, exactly one bit i set: `code` <= 11-i, `code_valid` = 1 for one cycle, go HELD.
  - IDLE, two or more bits set: go ERR. No valid pulse, `code` unchanged.
  - HELD, `deb` == 0: go IDLE.
  - HELD, any other `deb` value: stay, including added keys. No new event and no error.
  - ERR, `deb` == 0: go IDLE.
  - ERR, otherwise: stay.
- **Status outputs**: `key_held` = (state == HELD); `multi_err` = (state == ERR). Both are registered.
- **Code rules**: values 12..15 other than the reset value 4'b1111 are never produced. `code` holds between events.
- **Re-press**: one press and release produces exactly one `code_valid`. Pressing the same key again after a full release produces a new pulse with the same code.

## Timing
- **Reset**: all outputs, s1..s3, `cnt` and `deb` clear asynchronously. `code` = 4'b1111, `code_valid` = 0, `key_held` = 0, `multi_err` = 0, state IDLE.
- **Reset mid-operation**: same result. No pulse is generated after release of `rst_n` unless a key is still pressed. A key held through reset is re-accepted after a full debounce interval.
- **Press latency**: edge 0 is the first clock edge at which a new stable `inkey` level is sampled.
  - `deb` updates at edge DEBOUNCE_CYCLES+2.
  - `code_valid`, `code`, `key_held` (or `multi_err`) update at edge DEBOUNCE_CYCLES+3.
- **Release latency**: the return to IDLE has the same latency, so `key_held` and `multi_err` fall at edge DEBOUNCE_CYCLES+3.
- **Glitch rejection**: a glitch on any bit shorter than DEBOUNCE_CYCLES+1 clocks never reaches `deb`.
- **Simultaneous keys**: keys whose edges fall inside one debounce window are seen together. The result is ERR if two or more are set, never two pulses.
- **Pulse width**: `code_valid` is never high for two consecutive cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset values**: assert `rst_n` = 0 mid-run with `inkey` = 12'hFFF. Outputs are `code` = 4'hF, `code_valid` = 0, `key_held` = 0, `multi_err` = 0 immediately, with no clock required.
- **Single press**: drive `inkey` = 12'h7FF (line 11 pressed). Exactly one `code_valid` at edge 7 with `code` = 0, `key_held` = 1. Release to 12'hFFF: `key_held` = 0 at edge 7 after release.
- **Full code sweep**: press and release lines 0..11 in turn. Codes are 11,10,…,0 respectively, one pulse each, and `code` never reaches 12..14.
- **Bounce**: on line 5, toggle `inkey` every 3 clocks for 30 clocks, then hold it pressed. No pulse during the toggling; a single pulse with `code` = 6 at edge 7 after the toggling stops.
- **Multi-key**: drive `inkey` = 12'hFFC (lines 0 and 1). `multi_err` = 1, no `code_valid`, and `code` keeps its prior value. Release all: `multi_err` = 0 at edge 7.
- **Add key while held**: hold line 3 (`code` = 8), then add line 9. No pulse and no `multi_err`. Release all, then press line 9: one pulse with `code` = 2.
